// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner
//   Display stage for a 3-digit BCD value. It captures a 12-bit BCD word and
//   drives a common-anode multiplexed 7-segment display. One segment bus is
//   time-shared across three anodes. The block also does optional
//   leading-zero blanking and flags any captured nibble above 9.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   bcd_in     in   12  {hundreds[11:8], tens[7:4], ones[3:0]}
//   bcd_valid  in   1   capture bcd_in on this edge (last value wins)
//   lzb_en     in   1   leading-zero blanking enable, sampled every cycle
//   seg        out  7   {g,f,e,d,c,b,a}, active-low, registered
//   an         out  3   digit enables, active-low, an[0]=ones, registered
//   bcd_err    out  1   high while any captured nibble is > 9, registered
module bcd_7seg_scanner #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        lzb_en,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        bcd_err
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ONES     = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } digit_t;

  digit_t        r_idx;
  digit_t        w_idx_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic [11:0]   r_shadow;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    w_seg;
  logic [2:0]    w_an;
  logic          w_err;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b0111111;  // non-decimal nibble shows a dash
    endcase
    return p;
  endfunction

  // Dwell prescaler: tick on the last cycle of each digit's dwell.
  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The capture is independent of the scan. A load on a tick edge updates
  // the value and advances the digit on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (bcd_valid) begin
      r_shadow <= bcd_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= ONES;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_tick) begin
      case (r_idx)
        ONES:     w_idx_nxt = TENS;
        TENS:     w_idx_nxt = HUNDREDS;
        HUNDREDS: w_idx_nxt = ONES;
        default:  w_idx_nxt = ONES;
      endcase
    end
  end

  // Digit select and blanking. Blanking tests for zero, so an invalid nibble
  // is never blanked. The anode stays driven while blank, so frame timing
  // stays fixed.
  always_comb begin
    w_nib   = r_shadow[3:0];
    w_an    = 3'b110;
    w_blank = 1'b0;
    case (r_idx)
      ONES: begin
        w_nib = r_shadow[3:0];
        w_an  = 3'b110;
      end
      TENS: begin
        w_nib   = r_shadow[7:4];
        w_an    = 3'b101;
        w_blank = lzb_en && (r_shadow[11:8] == 4'd0) && (r_shadow[7:4] == 4'd0);
      end
      HUNDREDS: begin
        w_nib   = r_shadow[11:8];
        w_an    = 3'b011;
        w_blank = lzb_en && (r_shadow[11:8] == 4'd0);
      end
      default: begin
        w_nib = r_shadow[3:0];
        w_an  = 3'b110;
      end
    endcase
    w_seg = w_blank ? 7'h7F : f_decode(w_nib);
    w_err = (r_shadow[11:8] > 4'd9) || (r_shadow[7:4] > 4'd9) ||
            (r_shadow[3:0] > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= 7'h7F;
      an      <= 3'b111;
      bcd_err <= 1'b0;
    end else begin
      seg     <= w_seg;
      an      <= w_an;
      bcd_err <= w_err;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
module tb_bcd_7seg_scanner;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        bcd_valid;
  logic        lzb_en;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        bcd_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model state
  int unsigned n;          // edges since reset release
  logic [11:0] m_shadow;   // value the display should be showing
  logic [6:0]  e_seg;
  logic [2:0]  e_an;
  logic        e_err;
  logic [6:0]  DEC [0:9];

  bcd_7seg_scanner #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .lzb_en    (lzb_en),
    .seg       (seg),
    .an        (an),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

  // Advance one edge. Expected outputs come from the state before the edge.
  // The digit in view is (edges-before / CLK_DIV) mod 3, and the model value
  // is the last word captured before this edge.
  task automatic tick();
    int unsigned k;
    logic [3:0]  nib, h, t;
    logic        blank;
    k     = (n / CLK_DIV) % 3;
    nib   = m_shadow[4*k +: 4];
    h     = m_shadow[11:8];
    t     = m_shadow[7:4];
    blank = lzb_en && ((k == 2 && h == 4'd0) || (k == 1 && h == 4'd0 && t == 4'd0));
    e_seg = blank ? 7'h7F : ((nib > 4'd9) ? 7'b0111111 : DEC[nib]);
    e_an  = (k == 0) ? 3'b110 : ((k == 1) ? 3'b101 : 3'b011);
    e_err = 1'b0;
    for (int i = 0; i < 3; i++) if (m_shadow[4*i +: 4] > 4'd9) e_err = 1'b1;
    if (bcd_valid) m_shadow = bcd_in;
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    n        = 0;
    m_shadow = 12'h000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bcd_valid = 1'b0; bcd_in = 12'h000; lzb_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({seg, an, bcd_err} !== {7'h7F, 3'b111, 1'b0})
      $display("FAIL reset_state: seg=%b an=%b err=%b expected seg=1111111 an=111 err=0", seg, an, bcd_err);
    else n_pass++;
    release_reset();
  endtask

  task automatic test_scan_timing();
    for (int i = 1; i <= 13; i++) begin
      tick();
      n_chk++;
      if ({seg, an, bcd_err} !== {e_seg, e_an, e_err})
        $display("FAIL scan_timing cyc%0d: seg=%b an=%b err=%b expected seg=%b an=%b err=%b", i, seg, an, bcd_err, e_seg, e_an, e_err);
      else n_pass++;
    end
    // The first digit after reset release is the ones digit showing a zero.
    n_chk++;
    if (n != 13 || e_an !== 3'b110)
      $display("FAIL scan_wrap: edges=%0d an_model=%b expected edges=13 an=110", n, e_an);
    else n_pass++;
  endtask

  task automatic load_and_frame(input logic [11:0] v, input logic lzb, input string name);
    lzb_en = lzb; bcd_in = v; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      tick();
      n_chk++;
      if ({seg, an, bcd_err} !== {e_seg, e_an, e_err})
        $display("FAIL %s cyc%0d: seg=%b an=%b err=%b expected seg=%b an=%b err=%b", name, i, seg, an, bcd_err, e_seg, e_an, e_err);
      else n_pass++;
    end
  endtask

  task automatic test_decode();
    load_and_frame(12'h255, 1'b0, "val_255");
    load_and_frame(12'h007, 1'b1, "lzb_007_on");
    load_and_frame(12'h007, 1'b0, "lzb_007_off");
    load_and_frame(12'h0A3, 1'b1, "inval_0A3");
    load_and_frame(12'h000, 1'b1, "lzb_000");
    load_and_frame(12'h905, 1'b1, "lzb_905");
  endtask

  task automatic test_err_clear();
    lzb_en = 1'b0; bcd_in = 12'h0A3; bcd_valid = 1'b1;
    tick();
    bcd_in = 12'h123;
    tick();  // err raised from 0A3 shadow, 123 captured on this edge
    bcd_valid = 1'b0;
    n_chk++;
    if (bcd_err !== 1'b1 || e_err !== 1'b1)
      $display("FAIL err_set: err=%b expected 1", bcd_err);
    else n_pass++;
    tick();
    n_chk++;
    if (bcd_err !== 1'b0)
      $display("FAIL err_clear: err=%b expected 0", bcd_err);
    else n_pass++;
  endtask

  task automatic test_mid_dwell_load();
    int unsigned guard = 0;
    lzb_en = 1'b0;
    // Reach the tens dwell with the count at 1, so n mod frame is CLK_DIV+1.
    while ((n % (3 * CLK_DIV)) != CLK_DIV + 1 && guard < 100) begin
      tick(); guard++;
    end
    bcd_in = 12'h111; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if ({seg, an, bcd_err} !== {e_seg, e_an, e_err})
        $display("FAIL mid_dwell cyc%0d: seg=%b an=%b expected seg=%b an=%b", i, seg, an, e_seg, e_an);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      bcd_valid = 1'($urandom_range(0, 1));
      lzb_en    = 1'($urandom_range(0, 1));
      bcd_in    = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                   4'($urandom_range(0, 11))};
      if ($urandom_range(0, 3) == 0) bcd_in[11:4] = 8'h00;
      tick();
      n_chk++;
      if ({seg, an, bcd_err} !== {e_seg, e_an, e_err})
        $display("FAIL back_to_back cyc%0d: seg=%b an=%b err=%b expected seg=%b an=%b err=%b", i, seg, an, bcd_err, e_seg, e_an, e_err);
      else n_pass++;
    end
    bcd_valid = 1'b0;
  endtask

  task automatic test_reset_midscan();
    int unsigned guard = 0;
    lzb_en = 1'b0; bcd_in = 12'h789; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    while ((n % (3 * CLK_DIV)) != 2 * CLK_DIV + 1 && guard < 100) begin
      tick(); guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({seg, an, bcd_err} !== {7'h7F, 3'b111, 1'b0})
      $display("FAIL reset_async: seg=%b an=%b err=%b expected seg=1111111 an=111 err=0", seg, an, bcd_err);
    else n_pass++;
    release_reset();
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      tick();
      n_chk++;
      if ({seg, an, bcd_err} !== {e_seg, e_an, e_err})
        $display("FAIL reset_restart cyc%0d: seg=%b an=%b expected seg=%b an=%b", i, seg, an, e_seg, e_an);
      else n_pass++;
    end
  endtask

  initial begin
    DEC[0] = 7'b1000000; DEC[1] = 7'b1111001; DEC[2] = 7'b0100100;
    DEC[3] = 7'b0110000; DEC[4] = 7'b0011001; DEC[5] = 7'b0010010;
    DEC[6] = 7'b0000010; DEC[7] = 7'b1111000; DEC[8] = 7'b0000000;
    DEC[9] = 7'b0010000;
    n = 0; m_shadow = 12'h000;
    test_reset();
    test_scan_timing();
    test_decode();
    test_err_clear();
    test_mid_dwell_load();
    test_back_to_back();
    test_reset_midscan();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
